// File: rtl/vector_control_sequencer_pkg.sv
// Shared definitions for the vector control sequencer: instruction types, ALU codes,
// the decoded control bundle and the sequencer FSM states.
package vcu_defs;

  typedef enum logic [1:0] {
    SYS = 2'b00,
    DP  = 2'b01,
    MEM = 2'b10,
    CTL = 2'b11
  } itype_t;

  // Same encoding the scalar ALU uses
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_CMP = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;
  localparam logic [2:0] ALU_LSL = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       sp_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       flags_write;
    logic       reg_src;
    logic [1:0] vsi_flag;
    logic       lds_flag;
    logic [2:0] alu_control;
  } ctrl_bundle_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/vector_control_sequencer_if.sv
// Decode-side handshake plus datapath-side beat bus of the vector control sequencer.
interface vector_control_sequencer_if #(
  parameter int LANES      = 4,
  parameter int BEAT_LANES = 1
);
  localparam int NUM_BEATS = LANES / BEAT_LANES;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic             in_valid;
  logic [6:0]       in_id;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             reg_write;
  logic             sp_write;
  logic             mem_to_reg;
  logic             mem_write;
  logic             flags_write;
  logic             reg_src;
  logic             lds_flag;
  logic [1:0]       vsi_flag;
  logic [2:0]       alu_control;
  logic [BW-1:0]    beat_idx;
  logic [LANES-1:0] lane_mask;
  logic             last_beat;

  modport master (
    output in_valid, in_id, out_ready,
    input  in_ready, out_valid, reg_write, sp_write, mem_to_reg, mem_write,
           flags_write, reg_src, lds_flag, vsi_flag, alu_control,
           beat_idx, lane_mask, last_beat
  );

  modport slave (
    input  in_valid, in_id, out_ready,
    output in_ready, out_valid, reg_write, sp_write, mem_to_reg, mem_write,
           flags_write, reg_src, lds_flag, vsi_flag, alu_control,
           beat_idx, lane_mask, last_beat
  );
endinterface

// File: rtl/vector_control_sequencer_decode.sv
// Combinational instruction-ID decoder: ID -> control bundle plus multi-beat flag.
module vcu_decode
  import vcu_defs::*;
#(
  parameter int NUM_BEATS = 4
) (
  input  logic [6:0]   id,
  output ctrl_bundle_t ctrl,
  output logic         multi
);
  itype_t     typ;
  logic [2:0] op;

  assign typ = itype_t'(id[6:5]);
  assign op  = id[4:2];

  always_comb begin
    ctrl  = '0;
    multi = 1'b0;
    case (typ)
      DP: begin
        ctrl.reg_write   = (op != ALU_CMP);
        ctrl.flags_write = (op == ALU_CMP);
        ctrl.lds_flag    = (op == ALU_MOV);
        ctrl.alu_control = op;
        ctrl.vsi_flag    = id[1:0];
        multi            = id[1] && (NUM_BEATS > 1);
      end
      MEM: begin
        // id[4] selects store (1) vs load (0)
        ctrl.reg_src    = id[4];
        ctrl.mem_write  = id[4];
        ctrl.sp_write   = id[4];
        ctrl.mem_to_reg = !id[4];
        ctrl.reg_write  = !id[4];
        ctrl.lds_flag   = 1'b1;
        ctrl.vsi_flag   = id[1:0];
        multi           = id[1] && (NUM_BEATS > 1);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/vector_control_sequencer.sv
// Sequencer that registers decoded controls and issues vector ops as lane-group beats.
// Optional VCU_PERF_CNT_EN adds saturating beat/stall performance counters.
module vector_control_sequencer
  import vcu_defs::*;
#(
  parameter int LANES      = 4,
  parameter int BEAT_LANES = 1,
  localparam int NUM_BEATS = LANES / BEAT_LANES,
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
`ifdef VCU_PERF_CNT_EN
  output logic [31:0] perf_beats,
  output logic [31:0] perf_stalls,
`endif
  vector_control_sequencer_if.slave bus
);
  localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BEATS - 1);

  state_t           state;
  ctrl_bundle_t     base_q, out_q, dc;
  logic             dm, vld_q, last_q, take;
  logic [BW-1:0]    idx_q, nidx;
  logic [LANES-1:0] mask_q, nmask, mask0;

  vcu_decode #(.NUM_BEATS(NUM_BEATS)) u_dec (
    .id   (bus.in_id),
    .ctrl (dc),
    .multi(dm)
  );

  assign nidx = idx_q + BW'(1);

  for (genvar g = 0; g < LANES; g++) begin : g_mask
    assign nmask[g] = (BW'(g / BEAT_LANES) == nidx);
    assign mask0[g] = (g < BEAT_LANES);
  end

  // Per-instruction side effects land only on the final beat
  function automatic ctrl_bundle_t beat_ctrl(input ctrl_bundle_t c, input logic last);
    ctrl_bundle_t r;
    r             = c;
    r.sp_write    = c.sp_write & last;
    r.flags_write = c.flags_write & last;
    return r;
  endfunction

  assign bus.in_ready = !flush && (!vld_q || (bus.out_ready && last_q));
  assign take         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      base_q <= '0;
      out_q  <= '0;
    end else if (flush) begin
      state  <= ST_IDLE;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      out_q  <= '0;
    end else if (take) begin
      // Covers both the idle load and the reload on a last-beat handshake
      state  <= ST_ISSUE;
      vld_q  <= 1'b1;
      idx_q  <= '0;
      mask_q <= dm ? mask0 : '1;
      last_q <= !dm;
      base_q <= dc;
      out_q  <= beat_ctrl(dc, !dm);
    end else begin
      case (state)
        ST_ISSUE: begin
          if (bus.out_ready) begin
            if (!last_q) begin
              idx_q  <= nidx;
              mask_q <= nmask;
              last_q <= (nidx == LAST_IDX);
              out_q  <= beat_ctrl(base_q, nidx == LAST_IDX);
            end else begin
              state  <= ST_IDLE;
              vld_q  <= 1'b0;
              idx_q  <= '0;
              mask_q <= '0;
              last_q <= 1'b0;
              out_q  <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.reg_write   = out_q.reg_write;
  assign bus.sp_write    = out_q.sp_write;
  assign bus.mem_to_reg  = out_q.mem_to_reg;
  assign bus.mem_write   = out_q.mem_write;
  assign bus.flags_write = out_q.flags_write;
  assign bus.reg_src     = out_q.reg_src;
  assign bus.lds_flag    = out_q.lds_flag;
  assign bus.vsi_flag    = out_q.vsi_flag;
  assign bus.alu_control = out_q.alu_control;
  assign bus.beat_idx    = idx_q;
  assign bus.lane_mask   = mask_q;
  assign bus.last_beat   = last_q;

`ifdef VCU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (vld_q && bus.out_ready && !(&perf_beats))
        perf_beats <= perf_beats + 32'd1;
      if (bus.in_valid && !bus.in_ready && !(&perf_stalls))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Directed bench for vector_control_sequencer (LANES=4, BEAT_LANES=1).
module tb_vector_control_sequencer;
  logic clk = 1'b0;
  logic rst, flush;
  int   checks = 0;
  int   failures = 0;

`ifdef VCU_PERF_CNT_EN
  logic [31:0] perf_beats, perf_stalls;
`endif

  vector_control_sequencer_if #(.LANES(4), .BEAT_LANES(1)) bus ();

  vector_control_sequencer #(.LANES(4), .BEAT_LANES(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
`ifdef VCU_PERF_CNT_EN
    .perf_beats (perf_beats),
    .perf_stalls(perf_stalls),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ID_ADD = 7'b0100000;
  localparam logic [6:0] ID_STR = 7'b1010010;  // vector store
  localparam logic [6:0] ID_CMP = 7'b0110110;  // vector CMP (op 101)
  localparam logic [6:0] ID_LDR = 7'b1000000;
  localparam logic [6:0] ID_MOV = 7'b0111000;  // scalar MOV (op 110)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the common beat fields in one call
  task automatic beat(input string tag, input logic v, input logic [3:0] m,
                      input logic [1:0] idx, input logic lst);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, ".mask"},  32'(bus.lane_mask), 32'(m));
    chk({tag, ".idx"},   32'(bus.beat_idx),  32'(idx));
    chk({tag, ".last"},  32'(bus.last_beat), 32'(lst));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_id = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    beat("rst", 1'b0, 4'b0000, 2'd0, 1'b0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst.alu", 32'(bus.alu_control), 32'd0);
    rst = 1'b0;
    tick();

    // Vector STR, in_valid held through the stall cycles
    bus.in_valid = 1'b1; bus.in_id = ID_STR; bus.out_ready = 1'b1;
    tick();
    beat("str0", 1'b1, 4'b0001, 2'd0, 1'b0);
    chk("str0.mem_write", 32'(bus.mem_write), 32'd1);
    chk("str0.sp_write", 32'(bus.sp_write), 32'd0);
    chk("str0.reg_src", 32'(bus.reg_src), 32'd1);
    chk("str0.reg_write", 32'(bus.reg_write), 32'd0);
    chk("str0.vsi", 32'(bus.vsi_flag), 32'd2);
    chk("str0.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    beat("str1", 1'b1, 4'b0010, 2'd1, 1'b0);
    chk("str1.mem_write", 32'(bus.mem_write), 32'd1);
    chk("str1.sp_write", 32'(bus.sp_write), 32'd0);
    chk("str1.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    beat("str2", 1'b1, 4'b0100, 2'd2, 1'b0);
    chk("str2.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    beat("str3", 1'b1, 4'b1000, 2'd3, 1'b1);
    chk("str3.mem_write", 32'(bus.mem_write), 32'd1);
    chk("str3.sp_write", 32'(bus.sp_write), 32'd1);
    chk("str3.in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("str.done", 32'(bus.out_valid), 32'd0);
`ifdef VCU_PERF_CNT_EN
    chk("perf_beats", perf_beats, 32'd4);
    chk("perf_stalls", perf_stalls, 32'd3);
`endif

    // Scalar ADD
    bus.in_valid = 1'b1; bus.in_id = ID_ADD;
    tick();
    beat("add", 1'b1, 4'b1111, 2'd0, 1'b1);
    chk("add.reg_write", 32'(bus.reg_write), 32'd1);
    chk("add.alu", 32'(bus.alu_control), 32'd0);
    chk("add.flags", 32'(bus.flags_write), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("add.done", 32'(bus.out_valid), 32'd0);

    // Vector CMP with out_ready toggling
    bus.in_valid = 1'b1; bus.in_id = ID_CMP; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    beat("cmp0", 1'b1, 4'b0001, 2'd0, 1'b0);
    chk("cmp0.alu", 32'(bus.alu_control), 32'd5);
    chk("cmp0.flags", 32'(bus.flags_write), 32'd0);
    chk("cmp0.reg_write", 32'(bus.reg_write), 32'd0);
    tick();
    beat("cmp0h", 1'b1, 4'b0001, 2'd0, 1'b0);
    bus.out_ready = 1'b1; tick();
    beat("cmp1", 1'b1, 4'b0010, 2'd1, 1'b0);
    bus.out_ready = 1'b0; tick();
    beat("cmp1h", 1'b1, 4'b0010, 2'd1, 1'b0);
    chk("cmp1h.flags", 32'(bus.flags_write), 32'd0);
    bus.out_ready = 1'b1; tick();
    beat("cmp2", 1'b1, 4'b0100, 2'd2, 1'b0);
    bus.out_ready = 1'b0; tick();
    beat("cmp2h", 1'b1, 4'b0100, 2'd2, 1'b0);
    bus.out_ready = 1'b1; tick();
    beat("cmp3", 1'b1, 4'b1000, 2'd3, 1'b1);
    chk("cmp3.flags", 32'(bus.flags_write), 32'd1);
    chk("cmp3.reg_write", 32'(bus.reg_write), 32'd0);
    bus.out_ready = 1'b0; tick();
    beat("cmp3h", 1'b1, 4'b1000, 2'd3, 1'b1);
    chk("cmp3h.flags", 32'(bus.flags_write), 32'd1);
    bus.out_ready = 1'b1; tick();
    chk("cmp.done", 32'(bus.out_valid), 32'd0);

    // Back-to-back LDR then MOV
    bus.in_valid = 1'b1; bus.in_id = ID_LDR;
    tick();
    beat("ldr", 1'b1, 4'b1111, 2'd0, 1'b1);
    chk("ldr.mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
    chk("ldr.reg_write", 32'(bus.reg_write), 32'd1);
    chk("ldr.lds", 32'(bus.lds_flag), 32'd1);
    chk("ldr.mem_write", 32'(bus.mem_write), 32'd0);
    chk("ldr.in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_id = ID_MOV;
    tick();
    beat("mov", 1'b1, 4'b1111, 2'd0, 1'b1);
    chk("mov.lds", 32'(bus.lds_flag), 32'd1);
    chk("mov.alu", 32'(bus.alu_control), 32'd6);
    chk("mov.mem_to_reg", 32'(bus.mem_to_reg), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("mov.done", 32'(bus.out_valid), 32'd0);

    // Flush at beat 1
    bus.in_valid = 1'b1; bus.in_id = ID_STR;
    tick();
    bus.in_valid = 1'b0;
    tick();
    beat("fl1", 1'b1, 4'b0010, 2'd1, 1'b0);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_id = ID_ADD;
    #1;
    chk("fl.in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    beat("fl.after", 1'b0, 4'b0000, 2'd0, 1'b0);
    flush = 1'b0;
    #1;
    chk("fl.in_ready2", 32'(bus.in_ready), 32'd1);
    tick();
    beat("fl.add", 1'b1, 4'b1111, 2'd0, 1'b1);
    chk("fl.add.reg_write", 32'(bus.reg_write), 32'd1);
    bus.in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-sequence
    bus.in_valid = 1'b1; bus.in_id = ID_STR;
    tick();
    bus.in_valid = 1'b0;
    tick();
    beat("ar1", 1'b1, 4'b0010, 2'd1, 1'b0);
    #2 rst = 1'b1;
    #1;
    beat("ar", 1'b0, 4'b0000, 2'd0, 1'b0);
    chk("ar.mem_write", 32'(bus.mem_write), 32'd0);
    chk("ar.in_ready", 32'(bus.in_ready), 32'd1);
`ifdef VCU_PERF_CNT_EN
    chk("ar.perf_beats", perf_beats, 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("ar.post", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
